// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline. It merges hazard indications with the
// data-memory handshake into stage enables, and keeps saturating stall/flush counters.
module pipeline_stall_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             load_use_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic             pc_we_o,
  output logic             if_id_we_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             back_we_o,
  output logic             busy_o,
  output logic             error_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    ST_HALT,
    ST_RUN,
    ST_MEM_WAIT,
    ST_ERROR
  } state_e;

  localparam logic [15:0]      TimeoutVal = 16'(TIMEOUT);
  localparam logic [CNT_W-1:0] CntMax     = '1;

  state_e           state_q, state_d;
  logic             luPrev_q, luPrev_d;
  logic [15:0]      waitCnt_q, waitCnt_d;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

  logic active;
  logic freeze;
  logic luFire;

  always_comb begin
    active = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);
    freeze = ((state_q == ST_RUN) && dmem_req_i && !dmem_ack_i) ||
             ((state_q == ST_MEM_WAIT) && !dmem_ack_i);
    luFire = active && !freeze && load_use_i && !luPrev_q;
  end

  // A load-use bubble outranks a taken branch: the branch was resolved with stale operands.
  always_comb begin
    pc_we_o        = 1'b0;
    if_id_we_o     = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    back_we_o      = 1'b0;
    if (active && !freeze) begin
      back_we_o = 1'b1;
      if (luFire) begin
        id_ex_bubble_o = 1'b1;
      end else begin
        pc_we_o       = 1'b1;
        if_id_we_o    = 1'b1;
        if_id_flush_o = branch_taken_i;
      end
    end
  end

  assign busy_o      = freeze || (state_q == ST_MEM_WAIT);
  assign error_o     = (state_q == ST_ERROR);
  assign stall_cnt_o = stallCnt_q;
  assign flush_cnt_o = flushCnt_q;

  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    luPrev_d  = luPrev_q;
    unique case (state_q)
      ST_HALT: begin
        if (start_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (dmem_req_i && !dmem_ack_i) begin
          state_d   = ST_MEM_WAIT;
          waitCnt_d = '0;
        end
      end
      ST_MEM_WAIT: begin
        waitCnt_d = waitCnt_q + 16'd1;
        if (dmem_ack_i) state_d = ST_RUN;
        else if (waitCnt_d == TimeoutVal) state_d = ST_ERROR;
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_HALT;
    endcase
    // lu history survives a freeze so the bubble is still issued once the memory answers
    if (active && !freeze) luPrev_d = luFire;
  end

  always_comb begin
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (active && !pc_we_o && (stallCnt_q != CntMax)) stallCnt_d = stallCnt_q + CNT_W'(1);
    if (if_id_flush_o && (flushCnt_q != CntMax)) flushCnt_d = flushCnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_HALT;
      luPrev_q   <= 1'b0;
      waitCnt_q  <= '0;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      luPrev_q   <= luPrev_d;
      waitCnt_q  <= waitCnt_d;
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios plus random stimulus,
// all compared against a behavioural model of the stall/flush rules.
module tb_pipeline_stall_ctrl;

  localparam int TO   = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  // stimulus vector bits {start, load_use, branch, req, ack}
  localparam logic [4:0] S = 5'b10000;
  localparam logic [4:0] L = 5'b01000;
  localparam logic [4:0] B = 5'b00100;
  localparam logic [4:0] Q = 5'b00010;
  localparam logic [4:0] A = 5'b00001;
  localparam logic [4:0] N = 5'b00000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, lu = 1'b0, br = 1'b0, req = 1'b0, ack = 1'b0;
  logic pcWe, ifIdWe, ifIdFlush, idExBubble, backWe, busy, err;
  logic [CW-1:0] stallCnt, flushCnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .load_use_i(lu),
    .branch_taken_i(br), .dmem_req_i(req), .dmem_ack_i(ack),
    .pc_we_o(pcWe), .if_id_we_o(ifIdWe), .if_id_flush_o(ifIdFlush),
    .id_ex_bubble_o(idExBubble), .back_we_o(backWe), .busy_o(busy),
    .error_o(err), .stall_cnt_o(stallCnt), .flush_cnt_o(flushCnt)
  );

  typedef enum {M_HALT, M_RUN, M_WAIT, M_ERR} mode_t;
  mode_t mMode;
  int    mWaited;
  bit    mLuPrev;
  int    mStall;
  int    mFlush;

  function automatic logic [6:0] gotOut();
    return {pcWe, ifIdWe, ifIdFlush, idExBubble, backWe, busy, err};
  endfunction

  function automatic bit modelStuck(input logic [4:0] v);
    return (mMode == M_WAIT && !v[0]) || (mMode == M_RUN && v[1] && !v[0]);
  endfunction

  // expected {pc_we, if_id_we, flush, bubble, back_we, busy, error}
  function automatic logic [6:0] expectOut(input logic [4:0] v);
    bit live = (mMode == M_RUN) || (mMode == M_WAIT);
    bit stuck = modelStuck(v);
    logic [4:0] en;
    if (!live || stuck) en = 5'b00000;
    else if (v[3] && !mLuPrev) en = 5'b00011;
    else en = {2'b11, v[2], 2'b01};
    return {en, stuck || (mMode == M_WAIT), mMode == M_ERR};
  endfunction

  task automatic modelReset();
    mMode = M_HALT; mWaited = 0; mLuPrev = 0; mStall = 0; mFlush = 0;
  endtask

  task automatic drive(input logic [4:0] v);
    {start, lu, br, req, ack} = v;
    @(negedge clk);
  endtask

  task automatic tick();
    logic [4:0] v = {start, lu, br, req, ack};
    logic [6:0] e = expectOut(v);
    bit stuck = modelStuck(v);
    @(posedge clk);
    case (mMode)
      M_HALT: if (v[4]) mMode = M_RUN;
      M_RUN, M_WAIT: begin
        if (!e[6] && mStall < CMAX) mStall++;
        if (e[4] && mFlush < CMAX) mFlush++;
        if (!stuck) mLuPrev = e[3];
        if (mMode == M_RUN) begin
          if (v[1] && !v[0]) begin mMode = M_WAIT; mWaited = 0; end
        end else begin
          mWaited++;
          if (v[0]) mMode = M_RUN;
          else if (mWaited >= TO) mMode = M_ERR;
        end
      end
      default: ;
    endcase
    #1;
  endtask

  task automatic doReset();
    {start, lu, br, req, ack} = N;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    modelReset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    total++;
    if (gotOut() !== 7'b0) begin
      bad++; $display("[TB] FAIL reset_outs got=%b want=%b", gotOut(), 7'b0);
    end
    total++;
    if (stallCnt !== '0 || flushCnt !== '0) begin
      bad++; $display("[TB] FAIL reset_cnts got=%0d/%0d want=0/0", stallCnt, flushCnt);
    end
    doReset();
  endtask

  task automatic test_run();
    logic [4:0] seq [6] = '{S, N, N, S, N, N};
    doReset();
    foreach (seq[i]) begin
      drive(seq[i]);
      total++;
      if (gotOut() !== expectOut(seq[i])) begin
        bad++; $display("[TB] FAIL run c%0d got=%b want=%b", i, gotOut(), expectOut(seq[i]));
      end
      tick();
    end
    drive(N);
    total++;
    if (gotOut() !== 7'b1100100 || stallCnt !== '0) begin
      bad++; $display("[TB] FAIL run_final got=%b/%0d want=1100100/0", gotOut(), stallCnt);
    end
    tick();
  endtask

  task automatic test_load_use();
    logic [4:0] seq [5] = '{S, L, L, L, N};
    doReset();
    foreach (seq[i]) begin
      drive(seq[i]);
      total++;
      if (gotOut() !== expectOut(seq[i])) begin
        bad++; $display("[TB] FAIL load_use c%0d got=%b want=%b", i, gotOut(), expectOut(seq[i]));
      end
      tick();
    end
    total++;
    if (stallCnt !== CW'(2)) begin
      bad++; $display("[TB] FAIL load_use_stall got=%0d want=2", stallCnt);
    end
  endtask

  task automatic test_branch_vs_load_use();
    logic [4:0] seq [4] = '{S, L | B, B, N};
    doReset();
    foreach (seq[i]) begin
      drive(seq[i]);
      total++;
      if (gotOut() !== expectOut(seq[i])) begin
        bad++; $display("[TB] FAIL branch_lu c%0d got=%b want=%b", i, gotOut(), expectOut(seq[i]));
      end
      tick();
    end
    total++;
    if (flushCnt !== CW'(1)) begin
      bad++; $display("[TB] FAIL branch_flush_cnt got=%0d want=1", flushCnt);
    end
  endtask

  task automatic test_mem_miss();
    logic [4:0] seq [8] = '{S, Q, Q, Q, Q, Q | A, N, Q | A};
    doReset();
    foreach (seq[i]) begin
      drive(seq[i]);
      total++;
      if (gotOut() !== expectOut(seq[i]) || stallCnt !== CW'(mStall)) begin
        bad++; $display("[TB] FAIL mem_miss c%0d got=%b/%0d want=%b/%0d", i, gotOut(), stallCnt,
                        expectOut(seq[i]), mStall);
      end
      tick();
    end
    total++;
    if (stallCnt !== CW'(4)) begin
      bad++; $display("[TB] FAIL mem_miss_stall got=%0d want=4", stallCnt);
    end
  endtask

  task automatic test_lu_with_miss();
    logic [4:0] seq [6] = '{S, L | Q, L, L, L | A, N};
    doReset();
    foreach (seq[i]) begin
      drive(seq[i]);
      total++;
      if (gotOut() !== expectOut(seq[i])) begin
        bad++; $display("[TB] FAIL lu_miss c%0d got=%b want=%b", i, gotOut(), expectOut(seq[i]));
      end
      tick();
    end
    total++;
    if (stallCnt !== CW'(4)) begin
      bad++; $display("[TB] FAIL lu_miss_stall got=%0d want=4", stallCnt);
    end
  endtask

  task automatic test_timeout();
    logic [4:0] seq [12] = '{S, Q, N, N, N, N, N, N, N, N, N, N};
    doReset();
    foreach (seq[i]) begin
      drive(seq[i]);
      total++;
      if (gotOut() !== expectOut(seq[i])) begin
        bad++; $display("[TB] FAIL timeout c%0d got=%b want=%b", i, gotOut(), expectOut(seq[i]));
      end
      tick();
    end
    total++;
    if (gotOut() !== 7'b0000001) begin
      bad++; $display("[TB] FAIL timeout_error got=%b want=0000001", gotOut());
    end
    doReset();
    total++;
    if (gotOut() !== 7'b0) begin
      bad++; $display("[TB] FAIL timeout_clear got=%b want=0000000", gotOut());
    end
  endtask

  task automatic test_saturation();
    doReset();
    drive(S);
    tick();
    for (int i = 0; i < 40; i++) begin
      drive(L);
      total++;
      if (gotOut() !== expectOut(L) || stallCnt !== CW'(mStall)) begin
        bad++; $display("[TB] FAIL sat c%0d got=%b/%0d want=%b/%0d", i, gotOut(), stallCnt,
                        expectOut(L), mStall);
      end
      tick();
    end
    total++;
    if (stallCnt !== CW'(CMAX)) begin
      bad++; $display("[TB] FAIL sat_final got=%0d want=%0d", stallCnt, CMAX);
    end
  endtask

  task automatic test_reset_mid_wait();
    doReset();
    drive(S); tick();
    drive(Q); tick();
    drive(N);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("[TB] FAIL midwait_busy got=%b want=1", busy);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (gotOut() !== 7'b0 || stallCnt !== '0) begin
      bad++; $display("[TB] FAIL midwait_reset got=%b/%0d want=0000000/0", gotOut(), stallCnt);
    end
    doReset();
  endtask

  task automatic test_random();
    logic [4:0] v;
    doReset();
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 49) doReset();
      v = {($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0)};
      drive(v);
      total++;
      if (gotOut() !== expectOut(v) || stallCnt !== CW'(mStall) || flushCnt !== CW'(mFlush)) begin
        bad++; $display("[TB] FAIL random c%0d in=%b got=%b/%0d/%0d want=%b/%0d/%0d", i, v,
                        gotOut(), stallCnt, flushCnt, expectOut(v), mStall, mFlush);
      end
      tick();
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_run();
    test_load_use();
    test_branch_vs_load_use();
    test_mem_miss();
    test_lu_with_miss();
    test_timeout();
    test_saturation();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. It merges the load-use and branch-taken indications from hazard detection with the data-memory handshake into one set of stage write-enables, flush and bubble controls. A multi-cycle memory-wait state machine with timeout supports a non-single-cycle data memory or cache. Saturating performance counters record stall and flush activity. It sits between hazard detection / the MEM-stage memory port and the PC and pipeline registers.

## Interface
- TIMEOUT, 255: max cycles in MEM_WAIT before error (1..65535)
- CNT_W, 16: width of performance counters
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  leave HALT and begin execution
- load_use_i  in  1  load-use hazard from hazard detection (ID needs EX load result)
- branch_taken_i  in  1  branch in ID resolved taken
- dmem_req_i  in  1  MEM stage issuing a load/store this cycle
- dmem_ack_i  in  1  data memory completes the request this cycle
- pc_we_o  out  1  PC write enable
- if_id_we_o  out  1  IF/ID register write enable
- if_id_flush_o  out  1  zero IF/ID (squash fetched instruction)
- id_ex_bubble_o  out  1  load NOP controls into ID/EX
- back_we_o  out  1  ID/EX, EX/MEM, MEM/WB write enable
- busy_o  out  1  state is MEM_WAIT or stall asserted
- error_o  out  1  sticky memory-timeout error
- stall_cnt_o  out  CNT_W  cycles with pc_we_o=0 while in RUN/MEM_WAIT, saturating
- flush_cnt_o  out  CNT_W  cycles with if_id_flush_o=1, saturating

## Operation
- States: HALT, RUN, MEM_WAIT, ERROR. Reset → HALT.
- HALT: all enables 0, flush 0, bubble 0. start_i=1 → RUN next edge.
- Freeze condition F = (RUN & dmem_req_i & ~dmem_ack_i) | (MEM_WAIT & ~dmem_ack_i).
- Output priority in RUN/MEM_WAIT (combinational, same cycle):
  1. F: pc_we=if_id_we=back_we=0, flush=0, bubble=0.
  2. Load-use (load_use_i & ~lu_prev): pc_we=if_id_we=0, bubble=1, back_we=1, flush=0; branch_taken_i ignored (ID operands stale).
  3. branch_taken_i: pc_we=if_id_we=back_we=1, flush=1.
  4. Otherwise all enables 1, flush=0, bubble=0.
- lu_prev: register, set when case 2 fires, cleared on any other non-frozen cycle, held during F. Guarantees at most one consecutive load-use bubble even if load_use_i stays high.
- Transitions: RUN→MEM_WAIT when dmem_req_i & ~dmem_ack_i. MEM_WAIT→RUN on dmem_ack_i; the ack cycle itself is unfrozen (priority 2–4 apply). MEM_WAIT→ERROR when wait counter reaches TIMEOUT with no ack.
- Wait counter: cleared on RUN→MEM_WAIT, +1 per MEM_WAIT cycle; the first wait cycle counts as 1.
- ERROR: all enables 0, error_o=1, exits only via rst_i.
- Counters saturate at 2^CNT_W−1, never wrap; frozen by HALT/ERROR.
- busy_o = F | (state==MEM_WAIT).

## Timing
- Reset values: state HALT, lu_prev 0, wait counter 0, counters 0, error_o 0; outputs therefore enables 0, flush 0, bubble 0, busy 0.
- Reset asserted mid-MEM_WAIT: immediate return to HALT, outstanding request abandoned.
- Hit (req & ack same cycle): zero stall cycles.
- Miss with ack N cycles after req: exactly N frozen cycles, then normal advance on the ack cycle.
- Load-use: exactly 1 bubble cycle. Branch: 1 flush cycle, no stall.
- Load-use + memory miss same cycle: freeze wins; bubble issued on ack cycle.
- start_i ignored outside HALT.

## Test plan
- Reset, start_i pulse, no hazards → from cycle after start all enables 1, stall_cnt_o=0.
- load_use_i held high 3 cycles → bubble/pc_we=0 in cycle 1, normal cycle 2, bubble cycle 3; stall_cnt_o=2.
- branch_taken_i & load_use_i same cycle → bubble=1, flush=0; next cycle with branch_taken_i only → flush=1, flush_cnt_o=1.
- dmem_req_i with ack 4 cycles later → 4 frozen cycles (back_we=0), busy_o=1, state RUN after ack, stall_cnt_o=4.
- TIMEOUT=8, req with no ack → error_o=1 after 8 wait cycles, enables stay 0; rst_i clears to HALT, error_o=0.
- CNT_W=4, 20 load-use bubbles → stall_cnt_o saturates at 15.
